// File: rtl/cp0_tlb_op_ctrl_if.sv
// Shared TLB entry type and the controller's bus: commit-stage op channel, TLB array
// request/ack channel and cp0 update strobes. master = environment, slave = controller.
package cp0_tlb_op_ctrl_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'b00,
    OP_TLBWI = 2'b01,
    OP_TLBWR = 2'b10,
    OP_TLBP  = 2'b11
  } op_type_e;
endpackage

interface cp0_tlb_op_ctrl_if #(parameter int IDX_W = 4);
  import cp0_tlb_op_ctrl_pkg::*;

  // Op channel: an op transfers on a cycle where op_valid && op_ready; op_type and the cp0
  // registers must be valid alongside op_valid. TLB channel: tlb_req holds until tlb_ack,
  // and tlb_rdata/tlb_hit/tlb_hit_idx are only meaningful on the ack cycle.
  logic             op_valid;
  logic [1:0]       op_type;
  logic             op_ready;
  logic             flush;
  logic [31:0]      cp0_index;
  logic [31:0]      cp0_random;
  logic             tlb_req;
  logic             tlb_we;
  logic             tlb_probe;
  logic [IDX_W-1:0] tlb_idx;
  logic             tlb_ack;
  tlb_entry_t       tlb_rdata;
  logic             tlb_hit;
  logic [IDX_W-1:0] tlb_hit_idx;
  logic             tlbr_req;
  tlb_entry_t       tlbr_res;
  logic             tlbp_req;
  logic [31:0]      tlbp_res;
  logic             tlbwr_req;
  logic             op_done;
  logic             op_err;

  modport master (
    output op_valid, op_type, flush, cp0_index, cp0_random,
           tlb_ack, tlb_rdata, tlb_hit, tlb_hit_idx,
    input  op_ready, tlb_req, tlb_we, tlb_probe, tlb_idx,
           tlbr_req, tlbr_res, tlbp_req, tlbp_res, tlbwr_req, op_done, op_err
  );

  modport slave (
    input  op_valid, op_type, flush, cp0_index, cp0_random,
           tlb_ack, tlb_rdata, tlb_hit, tlb_hit_idx,
    output op_ready, tlb_req, tlb_we, tlb_probe, tlb_idx,
           tlbr_req, tlbr_res, tlbp_req, tlbp_res, tlbwr_req, op_done, op_err
  );
endinterface

// File: rtl/cp0_tlb_op_ctrl.sv
// Sequences one committed TLB op (TLBR/TLBWI/TLBWR/TLBP) at a time: TLB array transaction, then
// cp0 strobes and op_done. Define CP0_TLB_OP_TIMEOUT_EN to abort a BUSY op with no ack.
module cp0_tlb_op_ctrl
  import cp0_tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  cp0_tlb_op_ctrl_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, UPDATE = 2'd2, ABORT = 2'd3} state_e;

  state_e           state;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic             unused_hi;

  assign unused_hi     = ^{bus.cp0_index[31:IDX_W], bus.cp0_random[31:IDX_W]};
  // Kept low while rst is high so nothing is accepted in the reset cycle itself.
  assign bus.op_ready  = (state == IDLE) && !bus.flush && !rst;
  assign accept        = bus.op_valid && bus.op_ready;
  assign dbg_state     = state;

  always_comb begin
    sel_idx = '0;
    case (bus.op_type)
      OP_TLBR, OP_TLBWI: sel_idx = bus.cp0_index[IDX_W-1:0];
      OP_TLBWR:          sel_idx = bus.cp0_random[IDX_W-1:0];
      default:           sel_idx = '0;
    endcase
  end

`ifdef CP0_TLB_OP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
`else
  assign bus.op_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= OP_TLBR;
      bus.tlb_req   <= 1'b0;
      bus.tlb_we    <= 1'b0;
      bus.tlb_probe <= 1'b0;
      bus.tlb_idx   <= '0;
      bus.tlbr_req  <= 1'b0;
      bus.tlbr_res  <= '0;
      bus.tlbp_req  <= 1'b0;
      bus.tlbp_res  <= '0;
      bus.tlbwr_req <= 1'b0;
      bus.op_done   <= 1'b0;
`ifdef CP0_TLB_OP_TIMEOUT_EN
      bus.op_err    <= 1'b0;
      to_cnt        <= '0;
`endif
    end else begin
      bus.tlbr_req  <= 1'b0;
      bus.tlbp_req  <= 1'b0;
      bus.tlbwr_req <= 1'b0;
      bus.op_done   <= 1'b0;
`ifdef CP0_TLB_OP_TIMEOUT_EN
      bus.op_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= BUSY;
            op_q          <= bus.op_type;
            bus.tlb_req   <= 1'b1;
            bus.tlb_we    <= (bus.op_type == OP_TLBWI) || (bus.op_type == OP_TLBWR);
            bus.tlb_probe <= (bus.op_type == OP_TLBP);
            bus.tlb_idx   <= sel_idx;
`ifdef CP0_TLB_OP_TIMEOUT_EN
            to_cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.tlb_ack) begin
            state         <= UPDATE;
            bus.tlb_req   <= 1'b0;
            bus.tlb_we    <= 1'b0;
            bus.tlb_probe <= 1'b0;
            bus.op_done   <= 1'b1;
            bus.tlbr_req  <= (op_q == OP_TLBR);
            bus.tlbp_req  <= (op_q == OP_TLBP);
            bus.tlbwr_req <= (op_q == OP_TLBWR);
            // Each result register only follows its own op so cp0 sees a stable last value.
            if (op_q == OP_TLBR) bus.tlbr_res <= bus.tlb_rdata;
            if (op_q == OP_TLBP)
              bus.tlbp_res <= bus.tlb_hit ? {1'b0, {(31-IDX_W){1'b0}}, bus.tlb_hit_idx}
                                          : 32'h8000_0000;
          end
`ifdef CP0_TLB_OP_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= ABORT;
            bus.tlb_req   <= 1'b0;
            bus.tlb_we    <= 1'b0;
            bus.tlb_probe <= 1'b0;
          end else begin
            to_cnt        <= to_cnt + 1'b1;
          end
`endif
        end
        UPDATE: state <= IDLE;
        ABORT: begin
          // Reuse UPDATE as the done cycle, with no cp0 strobes.
          state       <= UPDATE;
          bus.op_done <= 1'b1;
`ifdef CP0_TLB_OP_TIMEOUT_EN
          bus.op_err  <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
